// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Ports: clk/reset (sync, active-high); pipeline side MemWriteM, MemtoRegM,
//   ALUOutM, WriteDataM -> ReadDataM, MemReady (low = stall);
//   backing memory mem_req/mem_we/mem_addr/mem_wdata (registered) with
//   mem_rdata/mem_ack responses; hit_count/miss_count saturating statistics.
module data_cache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemReady,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE, DONE} state_e;

    state_e           state_q, state_d;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      rdata_q;
    logic             mem_req_q, mem_we_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;
    logic [15:0]      hit_q, miss_q;

    // Byte offset is masked off so the stored request address is word aligned.
    logic [31:0]   addr_w;
    logic [IW-1:0] req_idx, mem_idx;
    logic [TW-1:0] req_tag, mem_tag;
    logic          req_hit, mem_hit, ack;

    assign addr_w  = ALUOutM & 32'hFFFF_FFFC;
    assign req_idx = addr_w[IW+1:2];
    assign req_tag = addr_w[31:IW+2];
    // Transfer-side lookups use the latched address, not the live pipeline bus.
    assign mem_idx = mem_addr_q[IW+1:2];
    assign mem_tag = mem_addr_q[31:IW+2];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
    // An acknowledge only counts while a request is actually outstanding.
    assign ack     = mem_req_q && mem_ack;

    logic start, start_we, hit_inc, miss_inc, fill, wr_upd;

    always_comb begin
        state_d   = state_q;
        MemReady  = 1'b0;
        ReadDataM = '0;
        start     = 1'b0;
        start_we  = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        fill      = 1'b0;
        wr_upd    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemWriteM) begin
                    start    = 1'b1;
                    start_we = 1'b1;
                    state_d  = WRITE;
                end else if (MemtoRegM) begin
                    if (req_hit) begin
                        MemReady  = 1'b1;
                        ReadDataM = data_q[req_idx];
                        hit_inc   = 1'b1;
                    end else begin
                        start    = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = READ_MISS;
                    end
                end else begin
                    MemReady = 1'b1;
                end
            end
            READ_MISS: begin
                if (ack) begin
                    fill    = 1'b1;
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (ack) begin
                    wr_upd  = mem_hit;
                    state_d = DONE;
                end
            end
            DONE: begin
                MemReady  = 1'b1;
                ReadDataM = rdata_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            MemReady  = 1'b1;
            ReadDataM = '0;
            fill      = 1'b0;
            wr_upd    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= start_we;
                mem_addr_q  <= addr_w;
                mem_wdata_q <= WriteDataM;
                rdata_q     <= '0;
            end else if (ack) begin
                mem_req_q <= 1'b0;
            end
            if (fill) begin
                valid_q[mem_idx] <= 1'b1;
                rdata_q          <= mem_rdata;
            end
            if (hit_inc && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            if (miss_inc && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[mem_idx]  <= mem_tag;
            data_q[mem_idx] <= mem_rdata;
        end else if (wr_upd) begin
            data_q[mem_idx] <= mem_wdata_q;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: random loads/stores against a line-level
// reference model, a latency-programmable memory responder and directed cases.
module tb_data_cache;
    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWriteM = 1'b0, MemtoRegM = 1'b0;
    logic [31:0] ALUOutM = '0, WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        MemReady;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    data_cache #(.LINES(LINES)) dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .MemReady(MemReady),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        int          stall;
        bit          hit;
    } exp_t;

    exp_t sb[$];
    exp_t cur_e;
    bit   mon_en = 1'b0;
    int   stall = 0;

    int          ack_delay = 0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic        cur_we = 1'b0;

    logic [31:0] bmem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    bit          m_v [LINES];
    logic [31:0] m_a [LINES];
    logic [31:0] m_d [LINES];
    int          m_hits = 0, m_miss = 0;

    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation whenever an access completes.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (MemWriteM || MemtoRegM) begin
                if (!MemReady) begin
                    stall++;
                end else if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: got completion expected none");
                end else begin
                    cur_e = sb.pop_front();
                    check("rdata", ReadDataM, cur_e.data);
                    check("stall", 32'(stall), 32'(cur_e.stall));
                    if (cur_e.hit) check("hit_no_req", {31'b0, mem_req}, 32'd0);
                    stall = 0;
                end
            end else begin
                check("idle_ready", {31'b0, MemReady}, 32'd1);
                check("idle_rdata", ReadDataM, 32'd0);
            end
        end
    end

    // Memory responder: acks ack_delay cycles after mem_req is first seen.
    int rcnt = 0;
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (rcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : dflt(mem_addr);
                    check("mem_addr", mem_addr, cur_addr);
                    check("mem_we", {31'b0, mem_we}, {31'b0, cur_we});
                    if (mem_we) begin
                        check("mem_wdata", mem_wdata, cur_wdata);
                        bmem[mem_addr] = mem_wdata;
                    end
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
                rcnt++;
            end else begin
                mem_ack = 1'b0;
                rcnt = 0;
            end
        end
    end

    task automatic do_req(bit we, bit ld, logic [31:0] a, logic [31:0] wd, int d);
        logic [31:0] w;
        int idx;
        int k;
        exp_t e;
        w = a & 32'hFFFF_FFFC;
        idx = int'((w >> 2) % LINES);
        if (we) begin
            rmem[w] = wd;
            if (m_v[idx] && m_a[idx] == w) m_d[idx] = wd;
            e.data = '0;
            e.stall = d + 2;
            e.hit = 1'b0;
        end else if (m_v[idx] && m_a[idx] == w) begin
            e.data = m_d[idx];
            e.stall = 0;
            e.hit = 1'b1;
            if (m_hits < 65535) m_hits++;
        end else begin
            e.data = rmem.exists(w) ? rmem[w] : dflt(w);
            m_v[idx] = 1'b1;
            m_a[idx] = w;
            m_d[idx] = e.data;
            e.stall = d + 2;
            e.hit = 1'b0;
            if (m_miss < 65535) m_miss++;
        end
        sb.push_back(e);
        ack_delay = d;
        cur_addr = w;
        cur_we = we;
        cur_wdata = wd;
        MemWriteM = we;
        MemtoRegM = ld;
        ALUOutM = a;
        WriteDataM = wd;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!MemReady && k < 200);
        if (!MemReady) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: got no MemReady expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
    endtask

    task automatic chk_counts(string tag);
        @(negedge clk);
        check({tag, "_hits"}, {16'b0, hit_count}, 32'(m_hits));
        check({tag, "_miss"}, {16'b0, miss_count}, 32'(m_miss));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        int k;
        int r;
        logic [31:0] a;
        bmem[32'h40] = 32'hDEAD_BEEF;
        rmem[32'h40] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, MemReady}, 32'd1);
        check("rst_rdata", ReadDataM, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_hits", {16'b0, hit_count}, 32'd0);
        check("rst_miss", {16'b0, miss_count}, 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        do_req(1'b0, 1'b1, 32'h40, '0, 0);
        chk_counts("cold");
        do_req(1'b0, 1'b1, 32'h40, '0, 0);
        chk_counts("warm");
        do_req(1'b1, 1'b0, 32'h40, 32'h1234_5678, 0);
        do_req(1'b0, 1'b1, 32'h40, '0, 0);
        do_req(1'b0, 1'b1, 32'h80, '0, 1);
        do_req(1'b0, 1'b1, 32'h40, '0, 2);
        chk_counts("conflict");
        do_req(1'b1, 1'b1, 32'h43, 32'hCAFE_0001, 1);
        do_req(1'b1, 1'b0, 32'h41, 32'hCAFE_0001, 0);
        do_req(1'b0, 1'b1, 32'h42, '0, 0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            do_req(r < 3, r >= 2, a, $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        chk_counts("random");

        mon_en = 1'b0;
        ack_delay = 1000;
        cur_we = 1'b0;
        MemtoRegM = 1'b1;
        ALUOutM = 32'hF000_0104;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_req && k < 20);
        check("mm_req_up", {31'b0, mem_req}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        MemtoRegM = 1'b0;
        @(negedge clk);
        check("mm_ready", {31'b0, MemReady}, 32'd1);
        check("mm_rdata", ReadDataM, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mm_req", {31'b0, mem_req}, 32'd0);
        check("mm_hits", {16'b0, hit_count}, 32'd0);
        check("mm_miss", {16'b0, miss_count}, 32'd0);
        for (int i = 0; i < LINES; i++) m_v[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
        sb.delete();
        stall = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_req(1'b0, 1'b1, 32'h40, '0, 0);
        chk_counts("post_rst");

        mon_en = 1'b0;
        MemtoRegM = 1'b1;
        ALUOutM = 32'h40;
        repeat (65540) @(posedge clk);
        #1;
        MemtoRegM = 1'b0;
        @(negedge clk);
        check("sat_hits", {16'b0, hit_count}, 32'h0000_FFFF);
        check("sat_miss", {16'b0, miss_count}, 32'(m_miss));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
